riscv_memory_arbiter: RTL and testbench
=======================================

RISCV_MEMORY_ARBITER -- requirements
Module: riscv_memory_arbiter

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 2: cycles from read grant to read data on mem_data_in.
REQ-002 SHALL have parameter MAX_DATA_STREAK, default 4: consecutive contested data grants before fetch is forced.
REQ-003 SHALL have port clk_in  input  1: sole clock, rising edge.
REQ-004 SHALL have port rst_in  input  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have ports if_req_in  input  1 and if_addr_in  input  32: fetch request and byte address (word read).
REQ-006 SHALL have ports if_gnt_out  output  1, if_rvalid_out  output  1, if_rdata_out  output  32: fetch grant and response.
REQ-007 SHALL have ports dm_req_in  input  1, dm_we_in  input  1, dm_addr_in  input  32, dm_wdata_in  input  32, dm_size_in  input  3: data request.
REQ-008 SHALL have ports dm_gnt_out  output  1, dm_rvalid_out  output  1, dm_rdata_out  output  32: data grant and load response.
REQ-009 SHALL have ports mem_addr_out  output  32, mem_wdata_out  output  32, mem_size_out  output  3, mem_we_out  output  1, mem_re_out  output  1: shared memory-interface request.
REQ-010 SHALL have port mem_data_in  input  32: formatted read data, valid exactly READ_LATENCY cycles after mem_re_out.

Function
REQ-011 SHALL grant at most one requester per cycle; grant is combinational from same-cycle requests and state.
REQ-012 SHALL treat a transfer as accepted in the cycle req and gnt are both high; requester holds req and fields stable until then.
REQ-013 SHALL, when only one requester is active, grant it.
REQ-014 SHALL, when both are active and streak < MAX_DATA_STREAK, grant data; when streak == MAX_DATA_STREAK, grant fetch.
REQ-015 SHALL increment streak on each data grant while if_req_in is high, saturating at MAX_DATA_STREAK; clear it on fetch grant or any cycle with if_req_in low.
REQ-016 SHALL drive mem_* from the granted requester; fetch drives size = MASK_W, we = 0, re = 1, wdata = 0.
REQ-017 SHALL drive data requests as mem_we_out = dm_we_in, mem_re_out = !dm_we_in.
REQ-018 SHALL drive all mem_* outputs to zero in cycles with no grant.
REQ-019 SHALL push a response tag {valid, owner} into a READ_LATENCY-deep shift register every cycle; valid = granted read.
REQ-020 SHALL assert exactly one of if_rvalid_out/dm_rvalid_out for one cycle when a valid tag exits, with rdata = mem_data_in; rdata is zero otherwise.
REQ-021 SHALL sustain one accepted read per cycle; back-to-back reads of mixed owners return in grant order.
REQ-022 SHALL complete writes at acceptance; writes produce no rvalid.
REQ-023 SHALL ignore dm_we_in, dm_wdata_in, dm_size_in when dm_req_in is low.

Reset
REQ-024 SHALL, while rst_in is low, force all outputs to zero, clear streak and every tag stage.
REQ-025 SHALL drop in-flight reads on reset: no rvalid is issued for grants made before reset asserted.
REQ-026 SHALL allow grants in the first cycle after rst_in deasserts.

Structure
REQ-027 SHALL take MASK_B/BU/H/HU/W size codes and an owner enum (OWNER_IF, OWNER_DM) from the shared riscv package.
REQ-028 SHALL build the tag shift register from the existing pipeline sub-module (PIPELINE_STAGES = READ_LATENCY, PIPELINE_WIDTH = 2).
REQ-029 SHALL contain no other sub-modules.

Verification
REQ-030 Fetch-only: if_req_in=1, if_addr_in=0x100 -> if_gnt_out same cycle, mem_addr_out=0x100, mem_re_out=1; if_rvalid_out two cycles later with mem_data_in value.
REQ-031 Store: dm_req_in=1, dm_we_in=1, dm_size_in=MASK_B, dm_wdata_in=0xAB -> dm_gnt_out=1, mem_we_out=1, mem_size_out=MASK_B; no rvalid follows.
REQ-032 Contention: both req held 10 cycles -> grants DM,DM,DM,DM,IF,DM,DM,DM,DM,IF.
REQ-033 Interleaved reads: IF read cycle 0, DM load cycle 1 -> if_rvalid_out cycle 2, dm_rvalid_out cycle 3, never both.
REQ-034 Reset mid-flight: DM load granted cycle 0, rst_in low cycle 1 -> no dm_rvalid_out; all outputs 0 during reset.
REQ-035 Streak clear: 3 contested DM grants, if_req_in low 1 cycle, then contention -> 4 more DM grants before IF.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: memory access size codes and
// memory-port owner identifiers.
package riscv_pkg;

  localparam logic [2:0] MASK_B  = 3'b000;
  localparam logic [2:0] MASK_H  = 3'b001;
  localparam logic [2:0] MASK_W  = 3'b010;
  localparam logic [2:0] MASK_BU = 3'b100;
  localparam logic [2:0] MASK_HU = 3'b101;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/riscv_memory_arbiter_pipeline.sv
// Fixed-depth shift register; every stage is cleared
// by the asynchronous active-low reset.
module riscv_memory_arbiter_pipeline #(
  parameter int PIPELINE_STAGES = 2,
  parameter int PIPELINE_WIDTH  = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [PIPELINE_WIDTH-1:0] data_in,
  output logic [PIPELINE_WIDTH-1:0] data_out
);

  logic [PIPELINE_STAGES-1:0][PIPELINE_WIDTH-1:0] stage_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= data_in;
      for (int i = 1; i < PIPELINE_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign data_out = stage_q[PIPELINE_STAGES-1];

endmodule

// File: rtl/riscv_memory_arbiter.sv
// Fetch/data arbiter for a single shared memory port with
// data priority bounded by a streak limit and tagged read returns.
module riscv_memory_arbiter
  import riscv_pkg::*;
#(
  parameter int READ_LATENCY    = 2,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        if_gnt_out,
  output logic        if_rvalid_out,
  output logic [31:0] if_rdata_out,
  input  logic        dm_req_in,
  input  logic        dm_we_in,
  input  logic [31:0] dm_addr_in,
  input  logic [31:0] dm_wdata_in,
  input  logic [2:0]  dm_size_in,
  output logic        dm_gnt_out,
  output logic        dm_rvalid_out,
  output logic [31:0] dm_rdata_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  output logic [2:0]  mem_size_out,
  output logic        mem_we_out,
  output logic        mem_re_out,
  input  logic [31:0] mem_data_in
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  logic [SW-1:0] streak_q, streak_d;
  logic          gnt_if, gnt_dm;
  logic [1:0]    tag_in, tag_out;
  owner_e        owner;
  logic          tag_vld;

  always_comb begin
    gnt_if = 1'b0;
    gnt_dm = 1'b0;
    if (rst_in) begin
      if (if_req_in && dm_req_in) begin
        gnt_if = (streak_q == STREAK_MAX);
        gnt_dm = (streak_q != STREAK_MAX);
      end else begin
        gnt_if = if_req_in;
        gnt_dm = dm_req_in;
      end
    end
  end

  // Streak counts data wins only while fetch is actually waiting.
  always_comb begin
    streak_d = streak_q;
    if (!if_req_in || gnt_if) begin
      streak_d = '0;
    end else if (gnt_dm && streak_q != STREAK_MAX) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  always_comb begin
    mem_addr_out  = '0;
    mem_wdata_out = '0;
    mem_size_out  = '0;
    mem_we_out    = 1'b0;
    mem_re_out    = 1'b0;
    unique case (1'b1)
      gnt_if: begin
        mem_addr_out = if_addr_in;
        mem_size_out = MASK_W;
        mem_re_out   = 1'b1;
      end
      gnt_dm: begin
        mem_addr_out  = dm_addr_in;
        mem_wdata_out = dm_wdata_in;
        mem_size_out  = dm_size_in;
        mem_we_out    = dm_we_in;
        mem_re_out    = !dm_we_in;
      end
      default: ;
    endcase
  end

  assign owner  = gnt_dm ? OWNER_DM : OWNER_IF;
  assign tag_in = {mem_re_out, owner};

  riscv_memory_arbiter_pipeline #(
    .PIPELINE_STAGES (READ_LATENCY),
    .PIPELINE_WIDTH  (2)
  ) u_tag_pipe (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .data_in  (tag_in),
    .data_out (tag_out)
  );

  assign tag_vld       = tag_out[1];
  assign if_rvalid_out = tag_vld && (owner_e'(tag_out[0]) == OWNER_IF);
  assign dm_rvalid_out = tag_vld && (owner_e'(tag_out[0]) == OWNER_DM);
  assign if_rdata_out  = if_rvalid_out ? mem_data_in : '0;
  assign dm_rdata_out  = dm_rvalid_out ? mem_data_in : '0;

  assign if_gnt_out = gnt_if;
  assign dm_gnt_out = gnt_dm;

endmodule

// File: tb/tb_riscv_memory_arbiter.sv
// Directed and random checks of riscv_memory_arbiter against
// a cycle-level reference model kept in the bench.
module tb_riscv_memory_arbiter;
  import riscv_pkg::*;

  localparam int LAT  = 2;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [2:0]  dm_size = '0;
  logic [31:0] mem_data = '0;

  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [2:0]  mem_size;
  logic        mem_we, mem_re;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int run = 0;
  int resp[int];
  logic g_i, g_d, obs_gd;
  logic [9:0] seq;

  riscv_memory_arbiter #(
    .READ_LATENCY    (LAT),
    .MAX_DATA_STREAK (MAXS)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .if_req_in     (if_req),
    .if_addr_in    (if_addr),
    .if_gnt_out    (if_gnt),
    .if_rvalid_out (if_rvalid),
    .if_rdata_out  (if_rdata),
    .dm_req_in     (dm_req),
    .dm_we_in      (dm_we),
    .dm_addr_in    (dm_addr),
    .dm_wdata_in   (dm_wdata),
    .dm_size_in    (dm_size),
    .dm_gnt_out    (dm_gnt),
    .dm_rvalid_out (dm_rvalid),
    .dm_rdata_out  (dm_rdata),
    .mem_addr_out  (mem_addr),
    .mem_wdata_out (mem_wdata),
    .mem_size_out  (mem_size),
    .mem_we_out    (mem_we),
    .mem_re_out    (mem_re),
    .mem_data_in   (mem_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    logic ei, ed, ewe, ere, eiv, edv;
    logic [31:0] ea, ew;
    logic [2:0] es;
    mem_data = $urandom;
    @(negedge clk);
    ei = 1'b0;
    ed = 1'b0;
    if (rst) begin
      if (if_req && dm_req) begin
        ei = (run >= MAXS);
        ed = !ei;
      end else begin
        ei = if_req;
        ed = dm_req;
      end
    end
    ea = '0; ew = '0; es = '0; ewe = 1'b0; ere = 1'b0;
    if (ei) begin
      ea = if_addr; es = MASK_W; ere = 1'b1;
    end else if (ed) begin
      ea = dm_addr; ew = dm_wdata; es = dm_size;
      ewe = dm_we; ere = !dm_we;
    end
    eiv = rst && resp.exists(cyc) && resp[cyc] == 0;
    edv = rst && resp.exists(cyc) && resp[cyc] == 1;
    chk("if_gnt", {31'b0, if_gnt}, {31'b0, ei});
    chk("dm_gnt", {31'b0, dm_gnt}, {31'b0, ed});
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ew);
    chk("mem_size", {29'b0, mem_size}, {29'b0, es});
    chk("mem_we", {31'b0, mem_we}, {31'b0, ewe});
    chk("mem_re", {31'b0, mem_re}, {31'b0, ere});
    chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, eiv});
    chk("dm_rvalid", {31'b0, dm_rvalid}, {31'b0, edv});
    chk("if_rdata", if_rdata, eiv ? mem_data : 32'h0);
    chk("dm_rdata", dm_rdata, edv ? mem_data : 32'h0);
    if (resp.exists(cyc)) resp.delete(cyc);
    if (!rst) begin
      run = 0;
      resp.delete();
    end else begin
      if (ere) resp[cyc + LAT] = ed ? 1 : 0;
      if (!if_req || ei) run = 0;
      else if (ed && run < MAXS) run++;
    end
    g_i = ei;
    g_d = ed;
    obs_gd = dm_gnt;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    if_req = 1'b0;
    dm_req = 1'b0;
    dm_we = 1'b0;
    step();
  endtask

  initial begin
    // reset state with requests pending
    if_req = 1'b1;
    dm_req = 1'b1;
    step();
    step();
    rst = 1'b1;
    idle();

    // fetch only
    if_req = 1'b1;
    if_addr = 32'h100;
    step();
    if_req = 1'b0;
    step();
    step();
    step();

    // byte store
    dm_req = 1'b1;
    dm_we = 1'b1;
    dm_size = MASK_B;
    dm_wdata = 32'hAB;
    dm_addr = 32'h40;
    step();
    idle();
    idle();
    idle();

    // sustained contention
    if_req = 1'b1;
    if_addr = 32'h200;
    dm_req = 1'b1;
    dm_we = 1'b0;
    dm_size = MASK_W;
    dm_addr = 32'h300;
    seq = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      seq = {seq[8:0], obs_gd};
    end
    chk("contention_seq", {22'b0, seq}, {22'b0, 10'b1111011110});
    idle();
    idle();
    idle();

    // interleaved fetch then load
    if_req = 1'b1;
    if_addr = 32'h104;
    step();
    if_req = 1'b0;
    dm_req = 1'b1;
    dm_we = 1'b0;
    dm_size = MASK_HU;
    dm_addr = 32'h402;
    step();
    idle();
    idle();
    idle();

    // reset while a load is in flight
    dm_req = 1'b1;
    dm_we = 1'b0;
    dm_addr = 32'h500;
    step();
    rst = 1'b0;
    if_req = 1'b1;
    step();
    step();
    rst = 1'b1;
    if_req = 1'b0;
    step();
    idle();
    idle();
    idle();

    // streak cleared by a fetch-idle cycle
    if_req = 1'b1;
    dm_req = 1'b1;
    dm_we = 1'b1;
    seq = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      seq = {seq[8:0], obs_gd};
    end
    if_req = 1'b0;
    step();
    seq = {seq[8:0], obs_gd};
    if_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      seq = {seq[8:0], obs_gd};
    end
    chk("streak_clear", {23'b0, seq[8:0]}, {23'b0, 9'b111111110});
    idle();
    idle();

    // random traffic, requests held until accepted
    for (int i = 0; i < 400; i++) begin
      if (!(if_req && !g_i)) begin
        if_req = ($urandom_range(0, 3) != 0);
        if_addr = {$urandom_range(0, 32'hFFFF), 2'b00};
      end
      if (!(dm_req && !g_d)) begin
        dm_req = ($urandom_range(0, 2) != 0);
        dm_we = $urandom_range(0, 1) == 1;
        dm_addr = $urandom;
        dm_wdata = $urandom;
        case ($urandom_range(0, 4))
          0: dm_size = MASK_B;
          1: dm_size = MASK_H;
          2: dm_size = MASK_W;
          3: dm_size = MASK_BU;
          default: dm_size = MASK_HU;
        endcase
      end
      if (i == 200) rst = 1'b0;
      if (i == 202) rst = 1'b1;
      step();
    end
    idle();
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
